// File: rtl/axi4s_vc_arbiter.sv
// ---------------------------------------------------------------------------
// axi4s_vc_arbiter
//
// Round-robin arbiter that shares one AXI4-Stream pixel path between NUM_REQ
// upstream packet sources (CSI-2 virtual channels) in front of the CPI output
// stage. Once a source is granted it keeps the path until its tlast beat is
// accepted. A watchdog reclaims the path from a source that stops presenting
// data mid-packet. The granted source index travels with the data so the
// downstream stage can tag frames.
//
// Ports:
//   axi4s_sclk_i   clock
//   axi4s_rst_i    synchronous active-high reset
//   req_en_i       per-source arbitration enable (only looked at in IDLE)
//   s_valid_i      per-source tvalid
//   s_ready_o      per-source tready (only the granted source sees m_ready_i)
//   s_data_i       packed source data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_last_i       per-source tlast (end of line packet)
//   m_valid_o      output tvalid
//   m_ready_i      output tready
//   m_data_o       output data (zero while idle)
//   m_last_o       output tlast (zero while idle)
//   m_src_o        index of the granted source, held through IDLE
//   err_timeout_o  one-cycle pulse after a watchdog release
// ---------------------------------------------------------------------------
module axi4s_vc_arbiter #(
  parameter int DATA_WIDTH = 48,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 1024,
  localparam int SRC_W     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          axi4s_sclk_i,
  input  logic                          axi4s_rst_i,
  input  logic [NUM_REQ-1:0]            req_en_i,
  input  logic [NUM_REQ-1:0]            s_valid_i,
  output logic [NUM_REQ-1:0]            s_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data_i,
  input  logic [NUM_REQ-1:0]            s_last_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [DATA_WIDTH-1:0]         m_data_o,
  output logic                          m_last_o,
  output logic [SRC_W-1:0]              m_src_o,
  output logic                          err_timeout_o
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t                 state_q, state_d;
  logic [SRC_W-1:0]       grant_q, grant_d;
  logic [SRC_W-1:0]       last_grant_q, last_grant_d;
  logic [15:0]            stall_cnt_q, stall_cnt_d;
  logic                   err_timeout_q, err_timeout_d;

  logic [NUM_REQ-1:0]     cand;
  logic                   win_found;
  logic [SRC_W-1:0]       win_idx;

  logic                   sel_valid;
  logic                   sel_last;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [15:0]            stall_inc;

  assign cand      = s_valid_i & req_en_i;
  assign stall_inc = stall_cnt_q + 16'd1;

  // Round-robin pick: distances from last_grant are scanned farthest first,
  // so the nearest candidate after last_grant is the one left standing.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (((int'(last_grant_q) + k) % NUM_REQ) == i && cand[i]) begin
          win_found = 1'b1;
          win_idx   = SRC_W'(i);
        end
      end
    end
  end

  // Select the granted source's beat.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == SRC_W'(i)) begin
        sel_valid = s_valid_i[i];
        sel_last  = s_last_i[i];
        sel_data  = s_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic. Any cycle where the granted source shows valid clears
  // the stall counter, so downstream backpressure can never trip the
  // watchdog; a last-beat handshake and a watchdog release are therefore
  // mutually exclusive.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    stall_cnt_d   = stall_cnt_q;
    err_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d     = win_idx;
          state_d     = BUSY;
          stall_cnt_d = '0;
        end
      end
      BUSY: begin
        if (sel_valid) begin
          stall_cnt_d = '0;
          if (m_ready_i && sel_last) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
          end
        end else if (TIMEOUT > 0) begin
          if (stall_inc == TIMEOUT_CNT) begin
            state_d       = IDLE;
            last_grant_d  = grant_q;
            stall_cnt_d   = '0;
            err_timeout_d = 1'b1;
          end else begin
            stall_cnt_d = stall_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. last_grant starts at the top index so source 0 is
  // first in line after reset.
  always_ff @(posedge axi4s_sclk_i) begin
    if (axi4s_rst_i) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_grant_q  <= SRC_W'(NUM_REQ - 1);
      stall_cnt_q   <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      stall_cnt_q   <= stall_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Zero-latency pass-through while BUSY. m_valid_o depends only on source
  // valid and state, never on m_ready_i.
  always_comb begin
    s_ready_o = '0;
    m_valid_o = 1'b0;
    m_data_o  = '0;
    m_last_o  = 1'b0;
    if (state_q == BUSY) begin
      m_valid_o = sel_valid;
      m_data_o  = sel_data;
      m_last_o  = sel_last;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q == SRC_W'(i)) begin
          s_ready_o[i] = m_ready_i;
        end
      end
    end
  end

  assign m_src_o       = grant_q;
  assign err_timeout_o = err_timeout_q;

endmodule

// File: tb/tb_axi4s_vc_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi4s_vc_arbiter
//
// Directed bench for axi4s_vc_arbiter with two sources, 48-bit data and an
// 8-cycle watchdog. Inputs change one time unit after the rising edge and
// outputs are compared one time unit later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_axi4s_vc_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  reqEn;
  logic [1:0]  sValid;
  logic [1:0]  sReady;
  logic [95:0] sData;
  logic [1:0]  sLast;
  logic        mValid;
  logic        mReady;
  logic [47:0] mData;
  logic        mLast;
  logic [0:0]  mSrc;
  logic        errTimeout;

  int checkCount;
  int errorCount;

  int beat [2];
  int pkt  [2];
  int expSrc;
  int expData;
  int readyPattern [18];
  int b1;

  axi4s_vc_arbiter #(
    .DATA_WIDTH(48),
    .NUM_REQ   (2),
    .TIMEOUT   (8)
  ) dut (
    .axi4s_sclk_i (clk),
    .axi4s_rst_i  (rst),
    .req_en_i     (reqEn),
    .s_valid_i    (sValid),
    .s_ready_o    (sReady),
    .s_data_i     (sData),
    .s_last_i     (sLast),
    .m_valid_o    (mValid),
    .m_ready_i    (mReady),
    .m_data_o     (mData),
    .m_last_o     (mLast),
    .m_src_o      (mSrc),
    .err_timeout_o(errTimeout)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] en, input logic [1:0] valid, input logic [1:0] last,
                               input logic [47:0] d0, input logic [47:0] d1, input logic ready);
    reqEn  = en;
    sValid = valid;
    sLast  = last;
    sData  = {d1, d0};
    mReady = ready;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  // Both sources always valid; each shows its own current beat.
  task automatic drivePair();
    logic [47:0] d0;
    logic [47:0] d1;
    d0 = 48'(32'h100 + 32'h10 * pkt[0] + beat[0]);
    d1 = 48'(32'h200 + 32'h10 * pkt[1] + beat[1]);
    applyStimulus(2'b11, 2'b11, {beat[1] == 2, beat[0] == 2}, d0, d1, 1'b1);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst    = 1'b1;
    reqEn  = 2'b00;
    sValid = 2'b00;
    sLast  = 2'b00;
    sData  = '0;
    mReady = 1'b0;
    $display("[TB] start");

    // ---- Reset values ----
    nextCycle();
    applyStimulus(2'b11, 2'b00, 2'b00, 48'h0, 48'h0, 1'b1);
    checkOutput("rst m_valid", 64'(mValid), 64'd0);
    checkOutput("rst s_ready", 64'(sReady), 64'd0);
    checkOutput("rst m_data", 64'(mData), 64'd0);
    checkOutput("rst m_last", 64'(mLast), 64'd0);
    checkOutput("rst m_src", 64'(mSrc), 64'd0);
    checkOutput("rst err", 64'(errTimeout), 64'd0);
    nextCycle();
    rst = 1'b0;

    // ---- Single 4-beat packet from source 0 ----
    applyStimulus(2'b11, 2'b01, 2'b00, 48'h1, 48'h0, 1'b1);
    checkOutput("t1 bubble m_valid", 64'(mValid), 64'd0);
    checkOutput("t1 bubble s_ready", 64'(sReady), 64'd0);
    nextCycle();
    for (int b = 1; b <= 4; b++) begin
      applyStimulus(2'b11, 2'b01, {1'b0, b == 4}, 48'(b), 48'h0, 1'b1);
      checkOutput("t1 m_valid", 64'(mValid), 64'd1);
      checkOutput("t1 m_data", 64'(mData), 64'(b));
      checkOutput("t1 m_last", 64'(mLast), 64'(b == 4));
      checkOutput("t1 m_src", 64'(mSrc), 64'd0);
      checkOutput("t1 s_ready", 64'(sReady), 64'b01);
      nextCycle();
    end
    applyStimulus(2'b11, 2'b00, 2'b00, 48'h0, 48'h0, 1'b1);
    checkOutput("t1 idle m_valid", 64'(mValid), 64'd0);
    checkOutput("t1 idle m_src held", 64'(mSrc), 64'd0);
    checkOutput("t1 idle m_data", 64'(mData), 64'd0);

    // ---- Alternating 3-beat packets, both sources always valid ----
    doReset();
    beat[0] = 0; beat[1] = 0; pkt[0] = 0; pkt[1] = 0;
    for (int p = 0; p < 4; p++) begin
      expSrc = p % 2;
      drivePair();
      checkOutput("t2 bubble m_valid", 64'(mValid), 64'd0);
      nextCycle();
      for (int b = 0; b < 3; b++) begin
        drivePair();
        expData = 32'h100 * (expSrc + 1) + 32'h10 * (p / 2) + b;
        checkOutput("t2 m_src", 64'(mSrc), 64'(expSrc));
        checkOutput("t2 m_data", 64'(mData), 64'(expData));
        checkOutput("t2 m_last", 64'(mLast), 64'(b == 2));
        nextCycle();
        beat[expSrc]++;
        if (beat[expSrc] == 3) begin
          beat[expSrc] = 0;
          pkt[expSrc]++;
        end
      end
    end

    // ---- Source 1 with toggling m_ready and a long downstream stall ----
    doReset();
    readyPattern = '{1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    applyStimulus(2'b11, 2'b10, 2'b00, 48'h0, 48'h300, 1'b1);
    checkOutput("t3 bubble m_valid", 64'(mValid), 64'd0);
    nextCycle();
    b1 = 0;
    for (int c = 0; c < 18; c++) begin
      applyStimulus(2'b11, 2'b10, {b1 == 4, 1'b0}, 48'h0, 48'(32'h300 + b1), readyPattern[c][0]);
      checkOutput("t3 m_src", 64'(mSrc), 64'd1);
      checkOutput("t3 s_ready", 64'(sReady), 64'({readyPattern[c][0], 1'b0}));
      checkOutput("t3 m_data", 64'(mData), 64'(32'h300 + b1));
      checkOutput("t3 err", 64'(errTimeout), 64'd0);
      nextCycle();
      if (readyPattern[c] == 1) b1++;
    end
    applyStimulus(2'b11, 2'b00, 2'b00, 48'h0, 48'h0, 1'b1);
    checkOutput("t3 end m_valid", 64'(mValid), 64'd0);
    checkOutput("t3 end err", 64'(errTimeout), 64'd0);

    // ---- Watchdog: source 0 stalls mid-packet, source 1 waiting ----
    doReset();
    applyStimulus(2'b11, 2'b11, 2'b10, 48'h401, 48'h500, 1'b1);
    checkOutput("t4 bubble m_valid", 64'(mValid), 64'd0);
    nextCycle();
    for (int b = 1; b <= 2; b++) begin
      applyStimulus(2'b11, 2'b11, 2'b10, 48'(32'h400 + b), 48'h500, 1'b1);
      checkOutput("t4 m_src", 64'(mSrc), 64'd0);
      checkOutput("t4 m_data", 64'(mData), 64'(32'h400 + b));
      checkOutput("t4 s_ready", 64'(sReady), 64'b01);
      nextCycle();
    end
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(2'b11, 2'b10, 2'b10, 48'h0, 48'h500, 1'b1);
      checkOutput("t4 stall m_valid", 64'(mValid), 64'd0);
      checkOutput("t4 stall s_ready", 64'(sReady), 64'b01);
      checkOutput("t4 stall err", 64'(errTimeout), 64'd0);
      nextCycle();
    end
    applyStimulus(2'b11, 2'b10, 2'b10, 48'h0, 48'h500, 1'b1);
    checkOutput("t4 release err", 64'(errTimeout), 64'd1);
    checkOutput("t4 release m_valid", 64'(mValid), 64'd0);
    checkOutput("t4 release s_ready", 64'(sReady), 64'd0);
    nextCycle();
    applyStimulus(2'b11, 2'b10, 2'b10, 48'h0, 48'h500, 1'b1);
    checkOutput("t4 regrant err", 64'(errTimeout), 64'd0);
    checkOutput("t4 regrant m_src", 64'(mSrc), 64'd1);
    checkOutput("t4 regrant m_valid", 64'(mValid), 64'd1);
    checkOutput("t4 regrant m_data", 64'(mData), 64'h500);
    nextCycle();

    // ---- req_en masks source 1; clearing req_en[0] mid-packet ----
    for (int n = 0; n < 2; n++) begin
      applyStimulus(2'b01, 2'b11, 2'b11, 48'(32'h600 + n), 48'h5ff, 1'b1);
      checkOutput("t5 bubble m_valid", 64'(mValid), 64'd0);
      nextCycle();
      applyStimulus(2'b01, 2'b11, 2'b11, 48'(32'h600 + n), 48'h5ff, 1'b1);
      checkOutput("t5 m_src", 64'(mSrc), 64'd0);
      checkOutput("t5 m_data", 64'(mData), 64'(32'h600 + n));
      nextCycle();
    end
    applyStimulus(2'b01, 2'b11, 2'b10, 48'h611, 48'h5ff, 1'b1);
    nextCycle();
    for (int b = 1; b <= 3; b++) begin
      applyStimulus(b == 1 ? 2'b01 : 2'b00, 2'b11, {1'b1, b == 3}, 48'(32'h610 + b), 48'h5ff, 1'b1);
      checkOutput("t5 en drop m_valid", 64'(mValid), 64'd1);
      checkOutput("t5 en drop m_src", 64'(mSrc), 64'd0);
      checkOutput("t5 en drop m_data", 64'(mData), 64'(32'h610 + b));
      nextCycle();
    end
    for (int c = 0; c < 2; c++) begin
      applyStimulus(2'b00, 2'b11, 2'b11, 48'h0, 48'h5ff, 1'b1);
      checkOutput("t5 disabled m_valid", 64'(mValid), 64'd0);
      nextCycle();
    end

    // ---- Reset mid-packet (last_grant is 0 here, so source 1 wins) ----
    applyStimulus(2'b11, 2'b11, 2'b00, 48'h700, 48'h801, 1'b1);
    nextCycle();
    applyStimulus(2'b11, 2'b11, 2'b00, 48'h700, 48'h801, 1'b1);
    checkOutput("t6 beat1 m_src", 64'(mSrc), 64'd1);
    checkOutput("t6 beat1 m_data", 64'(mData), 64'h801);
    nextCycle();
    rst = 1'b1;
    applyStimulus(2'b11, 2'b11, 2'b00, 48'h700, 48'h802, 1'b1);
    checkOutput("t6 beat2 m_data", 64'(mData), 64'h802);
    nextCycle();
    applyStimulus(2'b11, 2'b11, 2'b00, 48'h700, 48'h803, 1'b1);
    checkOutput("t6 rst m_valid", 64'(mValid), 64'd0);
    checkOutput("t6 rst s_ready", 64'(sReady), 64'd0);
    checkOutput("t6 rst m_src", 64'(mSrc), 64'd0);
    checkOutput("t6 rst m_data", 64'(mData), 64'd0);
    checkOutput("t6 rst m_last", 64'(mLast), 64'd0);
    checkOutput("t6 rst err", 64'(errTimeout), 64'd0);
    rst = 1'b0;
    nextCycle();
    applyStimulus(2'b11, 2'b11, 2'b00, 48'h700, 48'h803, 1'b1);
    checkOutput("t6 after m_src", 64'(mSrc), 64'd0);
    checkOutput("t6 after m_valid", 64'(mValid), 64'd1);
    checkOutput("t6 after m_data", 64'(mData), 64'h700);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
